// File: rtl/capsense_timer.sv
// rtl/capsense_timer.sv - capacitive-sense charge-time scanner with baseline press detection
module capsense_timer #(
    parameter int N   = 4,
    parameter int CW  = 8,
    parameter int THR = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ena_i,
    input  logic            start_i,
    input  logic            recal_i,
    input  logic [N-1:0]    buttons_i,
    output logic            but_oe_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [N-1:0]    sampled_o,
    output logic            timeout_o,
    output logic [N*CW-1:0] count_o
);

    localparam logic [CW-1:0] MAX   = {CW{1'b1}};
    localparam logic [CW:0]   THR_W = (CW+1)'(THR);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        EVAL    = 2'd2
    } state_t;

    state_t                   r_state;
    logic [CW-1:0]            r_t;
    logic [N-1:0]             r_flag;
    logic [N-1:0][CW-1:0]     r_cnt;
    logic [N-1:0][CW-1:0]     r_base;
    logic                     r_base_valid;
    logic [N-1:0]             r_sampled;
    logic                     r_timeout;
    logic [N-1:0][CW-1:0]     r_count;
    logic                     r_done;
    logic                     r_busy;
    logic                     r_but_oe;

    logic [CW-1:0]            w_nt;
    logic [N-1:0]             w_flag_nxt;
    logic                     w_all_flagged;
    logic [N-1:0]             w_pressed;

    // Next tick value, flag set after this tick, and the press decision against baseline
    always_comb begin
        w_nt          = r_t + 1'b1;
        w_flag_nxt    = r_flag | buttons_i;
        w_all_flagged = &w_flag_nxt;
        w_pressed     = '0;
        for (int k = 0; k < N; k++) begin
            // widened by one bit so baseline+THR cannot wrap
            w_pressed[k] = ({1'b0, r_cnt[k]} >= ({1'b0, r_base[k]} + THR_W));
        end
    end

    // Scan FSM: all state and registered outputs; done_o is high for the whole EVAL cycle
    // and the results it announces are written at the end of that cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_t          <= '0;
            r_flag       <= '0;
            r_cnt        <= '0;
            r_base       <= '0;
            r_base_valid <= 1'b0;
            r_sampled    <= '0;
            r_timeout    <= 1'b0;
            r_count      <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_but_oe     <= 1'b1;
        end else begin
            // a recal request outside EVAL only arms re-baselining; EVAL overrides below
            if (recal_i) begin
                r_base_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state  <= MEASURE;
                        r_t      <= '0;
                        r_flag   <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_but_oe <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (ena_i) begin
                        r_t    <= w_nt;
                        r_flag <= w_flag_nxt;
                        for (int k = 0; k < N; k++) begin
                            if (!r_flag[k] && buttons_i[k]) begin
                                r_cnt[k] <= w_nt;
                            end
                        end
                        if (w_all_flagged) begin
                            r_state   <= EVAL;
                            r_timeout <= 1'b0;
                            r_done    <= 1'b1;
                        end else if (w_nt == MAX) begin
                            r_state   <= EVAL;
                            r_timeout <= 1'b1;
                            r_done    <= 1'b1;
                            // a button latching on this last tick also gets MAX, so no exception needed
                            for (int k = 0; k < N; k++) begin
                                if (!r_flag[k]) begin
                                    r_cnt[k] <= MAX;
                                end
                            end
                        end
                    end
                end
                EVAL: begin
                    r_state  <= IDLE;
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_but_oe <= 1'b1;
                    r_count  <= r_cnt;
                    if (!r_base_valid || recal_i) begin
                        r_base       <= r_cnt;
                        r_base_valid <= 1'b1;
                        r_sampled    <= '0;
                    end else begin
                        r_sampled <= w_pressed;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_but_oe <= 1'b1;
                end
            endcase
        end
    end

    assign but_oe_o  = r_but_oe;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign sampled_o = r_sampled;
    assign timeout_o = r_timeout;
    assign count_o   = r_count;

endmodule

// File: tb/tb_capsense_timer.sv
// tb/tb_capsense_timer.sv - directed and randomized scans checked against a tick-level behavioural model
module tb_capsense_timer;

    localparam int N     = 4;
    localparam int CW    = 8;
    localparam int THR   = 4;
    localparam int MAXV  = 255;
    localparam int NEVER = 100000;

    typedef int arr_t [N];

    logic            clk = 1'b0;
    logic            rst_i;
    logic            ena_i;
    logic            start_i;
    logic            recal_i;
    logic [N-1:0]    buttons_i;
    logic            but_oe_o;
    logic            busy_o;
    logic            done_o;
    logic [N-1:0]    sampled_o;
    logic            timeout_o;
    logic [N*CW-1:0] count_o;

    int checks = 0;
    int errors = 0;

    bit           m_base_valid;
    int           m_base  [N];
    int           m_count [N];
    logic [N-1:0] m_sampled;
    bit           m_timeout;

    capsense_timer #(.N(N), .CW(CW), .THR(THR)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .ena_i     (ena_i),
        .start_i   (start_i),
        .recal_i   (recal_i),
        .buttons_i (buttons_i),
        .but_oe_o  (but_oe_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .sampled_o (sampled_o),
        .timeout_o (timeout_o),
        .count_o   (count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*CW-1:0] pack_counts();
        logic [N*CW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*CW +: CW] = m_count[k][CW-1:0];
        return v;
    endfunction

    function automatic logic [N-1:0] pattern(input arr_t r, input arr_t f, input int t);
        logic [N-1:0] p;
        for (int k = 0; k < N; k++) p[k] = (t >= r[k]) && (t < f[k]);
        return p;
    endfunction

    // Each button's count is the first tick it is seen high; the scan ends at the latest
    // such tick, or at MAX with every never-charged button reported as MAX.
    task automatic model_scan(input arr_t r, input arr_t f, input bit recal_eval, output int end_tick);
        int  first [N];
        bit  never;
        never    = 1'b0;
        end_tick = 0;
        for (int k = 0; k < N; k++) begin
            first[k] = (r[k] < f[k] && r[k] <= MAXV) ? r[k] : NEVER;
            if (first[k] == NEVER) never = 1'b1;
            else if (first[k] > end_tick) end_tick = first[k];
        end
        if (never) end_tick = MAXV;
        for (int k = 0; k < N; k++) m_count[k] = (first[k] == NEVER) ? MAXV : first[k];
        m_timeout = never;
        if (!m_base_valid || recal_eval) begin
            for (int k = 0; k < N; k++) m_base[k] = m_count[k];
            m_base_valid = 1'b1;
            m_sampled    = '0;
        end else begin
            for (int k = 0; k < N; k++) m_sampled[k] = (m_count[k] >= m_base[k] + THR);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " done"},    done_o,    1'b0);
        chk({tag, " busy"},    busy_o,    1'b0);
        chk({tag, " but_oe"},  but_oe_o,  1'b1);
        chk({tag, " count"},   count_o,   pack_counts());
        chk({tag, " sampled"}, sampled_o, m_sampled);
        chk({tag, " timeout"}, timeout_o, m_timeout);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after EVAL.
    task automatic do_scan(input string tag, input arr_t r, input arr_t f,
                           input bit recal_mid, input bit recal_eval);
        int tick;
        int exp_end;
        bit got;
        tick = 0;
        got  = 1'b0;
        if (recal_mid) m_base_valid = 1'b0;
        model_scan(r, f, recal_eval, exp_end);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk({tag, " busy in measure"},   busy_o,   1'b1);
        chk({tag, " but_oe in measure"}, but_oe_o, 1'b0);
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (done_o) begin
                got = 1'b1;
                break;
            end
            recal_i = recal_mid && (cyc == 0);
            if (cyc % 3 == 2) begin
                tick++;
                ena_i     = 1'b1;
                start_i   = 1'b0;
                buttons_i = pattern(r, f, tick);
            end else begin
                ena_i     = 1'b0;
                buttons_i = N'($urandom);
                start_i   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        ena_i     = 1'b0;
        recal_i   = recal_eval;
        start_i   = 1'b1;
        buttons_i = N'($urandom);
        chk({tag, " done seen"},      got,       1'b1);
        chk({tag, " end tick"},       tick,      exp_end);
        chk({tag, " timeout at eval"}, timeout_o, m_timeout);
        @(negedge clk);
        start_i   = 1'b0;
        recal_i   = 1'b0;
        buttons_i = '0;
        check_idle_outputs(tag);
    endtask

    task automatic abort_scan(input string tag, input int at_tick);
        int tick;
        bit saw_done;
        tick     = 0;
        saw_done = 1'b0;
        start_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int cyc = 0; cyc < 100 && tick < at_tick; cyc++) begin
            if (done_o) saw_done = 1'b1;
            if (cyc % 3 == 2) begin
                tick++;
                ena_i     = 1'b1;
                buttons_i = 4'b0001;
                rst_i     = (tick == at_tick);
            end else begin
                ena_i     = 1'b0;
                start_i   = 1'b1;
                buttons_i = '0;
            end
            @(negedge clk);
            start_i = 1'b0;
        end
        if (done_o) saw_done = 1'b1;
        rst_i = 1'b0;
        ena_i = 1'b0;
        buttons_i = '0;
        chk({tag, " reached tick"}, tick, at_tick);
        chk({tag, " no done"}, saw_done, 1'b0);
        m_base_valid = 1'b0;
        for (int k = 0; k < N; k++) m_count[k] = 0;
        m_sampled = '0;
        m_timeout = 1'b0;
        check_idle_outputs(tag);
    endtask

    initial begin
        arr_t r;
        arr_t f;
        arr_t fn;
        bit   rm;
        bit   re;
        fn = '{NEVER, NEVER, NEVER, NEVER};
        rst_i = 1'b1; ena_i = 1'b0; start_i = 1'b0; recal_i = 1'b0; buttons_i = '0;
        m_base_valid = 1'b0;
        for (int k = 0; k < N; k++) begin m_count[k] = 0; m_base[k] = 0; end
        m_sampled = '0;
        m_timeout = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        check_idle_outputs("reset");

        r = '{10, 10, 11, 12};
        do_scan("first scan", r, fn, 1'b0, 1'b0);
        chk("first scan counts const", count_o, 32'h0C0B0A0A);

        r = '{10, 10, 15, 12};
        do_scan("press 15", r, fn, 1'b0, 1'b0);
        chk("press 15 const", sampled_o, 4'b0100);

        r = '{10, 10, 14, 12};
        do_scan("below thr 14", r, fn, 1'b0, 1'b0);
        chk("below thr const", sampled_o, 4'b0000);

        r = '{10, NEVER, 11, 12};
        do_scan("timeout", r, fn, 1'b0, 1'b0);
        chk("timeout const", sampled_o, 4'b0010);

        abort_scan("abort", 5);
        r = '{20, 20, 20, 20};
        do_scan("after abort", r, fn, 1'b0, 1'b0);

        r = '{20, 20, 30, 20};
        do_scan("recal eval", r, fn, 1'b0, 1'b1);
        chk("recal eval const", sampled_o, 4'b0000);
        r = '{20, 20, 34, 20};
        do_scan("new baseline", r, fn, 1'b0, 1'b0);
        chk("new baseline const", sampled_o, 4'b0100);

        r = '{1, 1, 1, 1};
        f = '{2, NEVER, NEVER, NEVER};
        do_scan("all at tick1", r, f, 1'b0, 1'b0);
        r = '{1, 2, 2, 2};
        do_scan("b0 falls", r, f, 1'b0, 1'b0);
        chk("b0 falls const", count_o, 32'h02020201);

        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < N; k++) begin
                r[k] = ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(1, 40));
                f[k] = ($urandom_range(0, 2) == 0) ? r[k] + int'($urandom_range(1, 50)) : NEVER;
            end
            rm = ($urandom_range(0, 7) == 0);
            re = ($urandom_range(0, 7) == 0);
            do_scan("random", r, f, rm, re);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/capsense_timer.md
CAPSENSE_TIMER -- requirements
Module: capsense_timer

Interface
REQ-001 Parameter N, default 4: number of capsense buttons, N >= 1.
REQ-002 Parameter CW, default 8: width of the per-button charge-time counter, CW >= 3; MAX = 2^CW-1.
REQ-003 Parameter THR, default 4: delta in ena_i ticks above baseline that marks a button pressed, 1 <= THR <= MAX.
REQ-004 Clocking and reset SHALL be: one clock; reset is synchronous and active-high. Ports clk_i and rst_i.
REQ-005 clk_i  in  1  system clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset.
REQ-007 ena_i  in  1  sampling tick, one clk_i cycle wide, arbitrary rate.
REQ-008 start_i  in  1  start one measurement scan; honoured only in IDLE.
REQ-009 recal_i  in  1  request re-baselining; sampled in any state.
REQ-010 buttons_i  in  N  button pad inputs, 1 = capacitor charged.
REQ-011 but_oe_o  out  1  pad discharge enable, 1 exactly while in IDLE.
REQ-012 busy_o  out  1  1 while in MEASURE or EVAL.
REQ-013 done_o  out  1  one-cycle pulse marking the end of a scan.
REQ-014 sampled_o  out  N  pressed flags from the last evaluated scan.
REQ-015 timeout_o  out  1  last scan hit MAX with at least one button uncharged.
REQ-016 count_o  out  N*CW  last captured charge times; button k occupies bits [k*CW+CW-1 : k*CW].

Function
REQ-017 The FSM SHALL have states IDLE, MEASURE and EVAL; it leaves IDLE only on start_i=1 and enters MEASURE on the next cycle.
REQ-018 On the IDLE->MEASURE transition, the block SHALL clear the tick counter t, all per-button latched flags and all working counts to 0.
REQ-019 In MEASURE, a cycle with ena_i=0 SHALL change no state.
REQ-020 On each MEASURE cycle with ena_i=1, the block SHALL compute nt=t+1 and set t=nt; for every button k with flag 0 and buttons_i[k]=1, it SHALL set flag k=1 and count k=nt.
REQ-021 After that update, if all flags are 1, the FSM SHALL go to EVAL with timeout_o set to 0.
REQ-022 Otherwise, if nt=MAX, the FSM SHALL go to EVAL with timeout_o set to 1, and every still-unflagged count SHALL be set to MAX.
REQ-023 Buttons that charge on the same tick SHALL receive equal counts; a button that falls back to 0 after latching SHALL keep its count.
REQ-024 EVAL SHALL last exactly one cycle; count_o SHALL be updated from the working counts and done_o=1 in that cycle; the FSM SHALL then return to IDLE.
REQ-025 In EVAL, if base_valid=0, the block SHALL copy the counts into per-button baseline registers, set base_valid=1, and set sampled_o to all 0.
REQ-026 In EVAL, if base_valid=1, it SHALL set sampled_o[k]=1 iff count_k >= baseline_k+THR, with the sum evaluated in CW+1 bits so there is no wrap.
REQ-027 recal_i=1 in any cycle SHALL clear base_valid, so the next EVAL re-baselines.
REQ-028 If recal_i=1 coincides with an EVAL cycle, that EVAL SHALL itself re-baseline.
REQ-029 start_i SHALL be ignored in MEASURE and EVAL.
REQ-030 start_i=1 in the IDLE cycle immediately following EVAL SHALL start a new scan.
REQ-031 sampled_o, count_o and timeout_o SHALL hold their values until the next EVAL.
REQ-032 Latency from accepting start_i to done_o SHALL be 1 cycle + (cycles to the terminating ena_i) + 1 cycle.

Reset
REQ-033 rst_i=1 SHALL force: state IDLE, t=0, flags=0, counts=0, baselines=0, base_valid=0, sampled_o=0, count_o=0, timeout_o=0, done_o=0, busy_o=0, but_oe_o=1.
REQ-034 rst_i SHALL take priority over all other inputs, including mid-MEASURE and during EVAL; the scan is aborted with no done_o pulse.

Verification (N=4, CW=8, THR=4, ena_i every 3rd cycle)
REQ-035 First scan after reset, buttons rise at ticks 10,10,11,12 -> done_o pulse, count_o={12,11,10,10} (button 3 down to 0), sampled_o=0000, baseline stored, timeout_o=0.
REQ-036 Second scan, button 2 rises at tick 15 and the others as in REQ-035 -> sampled_o=0100 (15>=11+4); a value of 14 on button 2 gives sampled_o=0000.
REQ-037 Button 1 never rises -> done_o at tick 255, count for button 1=255, timeout_o=1, sampled_o[1]=1 if baseline <= 251.
REQ-038 start_i pulsed during MEASURE, then rst_i asserted at tick 5 -> no done_o, but_oe_o=1 next cycle, all outputs 0, next scan re-baselines.
REQ-039 recal_i asserted in the EVAL cycle of a scan with a pressed button -> sampled_o=0000, baselines equal that scan's counts.
REQ-040 Button 0 high then low before termination, all buttons high together at tick 1 -> counts all 1, sampled latched counts unchanged by the later low.
